// File: rtl/mac_bist_ctrl.sv
// BIST initiator for the mac_test datapath: drives LFSR operand vectors, compacts
// the returned results into a 16-bit MISR and compares against a golden signature.
module mac_bist_ctrl #(
    parameter int unsigned RESULT_LATENCY = 2,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  vec_count,
    input  logic [15:0] expected_sig,
    input  logic [7:0]  mac_res_lo,
    input  logic [7:0]  mac_res_hi,
    output logic        mac_sel,
    output logic [7:0]  mac_a,
    output logic [7:0]  mac_b,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DRAIN, S_COMPARE} state_t;
    typedef logic [RESULT_LATENCY-1:0] vld_t;

    localparam logic [2:0] DRAIN_LAST = 3'(RESULT_LATENCY - 1);

    function automatic logic [15:0] step16(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] misr_q, misr_d;
    logic [7:0]  vcnt_q, vcnt_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic [15:0] exp_q, exp_d;
    vld_t        vld_q, vld_d;
    logic        mac_sel_q, mac_sel_d;
    logic [7:0]  mac_a_q, mac_a_d;
    logic [7:0]  mac_b_q, mac_b_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] sig_q, sig_d;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        misr_d    = misr_q;
        vcnt_d    = vcnt_q;
        dcnt_d    = dcnt_q;
        exp_d     = exp_q;
        mac_sel_d = mac_sel_q;
        mac_a_d   = mac_a_q;
        mac_b_d   = mac_b_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        sig_d     = sig_q;

        // The valid pipe tracks the driven vector; its tail marks the edge its result is sampled.
        vld_d = (vld_q << 1) | vld_t'(mac_sel_q);
        if (vld_q[RESULT_LATENCY-1]) begin
            misr_d = step16(misr_q) ^ {mac_res_hi, mac_res_lo};
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d  = expected_sig;
                    misr_d = '0;
                    pass_d = 1'b0;
                    sig_d  = '0;
                    busy_d = 1'b1;
                    if (vec_count != 8'd0) begin
                        state_d   = S_DRIVE;
                        mac_sel_d = 1'b1;
                        mac_a_d   = LFSR_SEED[7:0];
                        mac_b_d   = LFSR_SEED[15:8];
                        lfsr_d    = step16(LFSR_SEED);
                        vcnt_d    = vec_count - 8'd1;
                    end else begin
                        state_d = S_COMPARE;
                        lfsr_d  = LFSR_SEED;
                    end
                end
            end
            S_DRIVE: begin
                if (vcnt_q != 8'd0) begin
                    mac_a_d = lfsr_q[7:0];
                    mac_b_d = lfsr_q[15:8];
                    lfsr_d  = step16(lfsr_q);
                    vcnt_d  = vcnt_q - 8'd1;
                end else begin
                    state_d   = S_DRAIN;
                    mac_sel_d = 1'b0;
                    mac_a_d   = '0;
                    mac_b_d   = '0;
                    dcnt_d    = DRAIN_LAST;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == 3'd0) begin
                    state_d = S_COMPARE;
                end else begin
                    dcnt_d = dcnt_q - 3'd1;
                end
            end
            S_COMPARE: begin
                sig_d   = misr_q;
                pass_d  = (misr_q == exp_q);
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            lfsr_q    <= LFSR_SEED;
            misr_q    <= '0;
            vcnt_q    <= '0;
            dcnt_q    <= '0;
            exp_q     <= '0;
            vld_q     <= '0;
            mac_sel_q <= 1'b0;
            mac_a_q   <= '0;
            mac_b_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            sig_q     <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            misr_q    <= misr_d;
            vcnt_q    <= vcnt_d;
            dcnt_q    <= dcnt_d;
            exp_q     <= exp_d;
            vld_q     <= vld_d;
            mac_sel_q <= mac_sel_d;
            mac_a_q   <= mac_a_d;
            mac_b_q   <= mac_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            sig_q     <= sig_d;
        end
    end

    assign mac_sel   = mac_sel_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = sig_q;

endmodule
